// File: rtl/uart_rx_deserializer_if.sv
// Serial RX pin plus parallel byte/strobe/status outputs of the UART receiver.
interface uart_rx_deserializer_if;
  logic       rx_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx_data, input rx_byte, rx_valid, frame_err, busy);
  modport slave  (input rx_data, output rx_byte, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop synchroniser, start-glitch rejection, mid-bit
// sampling, framing-error detection and break hold-off.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                   hwclk,
  input  logic                   reset,
  uart_rx_deserializer_if.slave  bus
);

  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned DATA_W    = 8;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t              state, state_n;
  logic                sync1, rx_s;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    bit_idx, bit_idx_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic [DATA_W-1:0]   byte_q, byte_n;
  logic                valid_q, valid_n;
  logic                ferr_q, ferr_n;

  // Metastability guard; everything downstream sees only rx_s.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_data;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      byte_q  <= byte_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  // Counter clears on every state change so each phase times from zero.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    byte_n    = byte_q;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[DATA_W-1:1]};
          bit_idx_n = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(DATA_W - 1)) state_n = STOP;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK_WAIT;
          end
        end
      end

      // A held-low line must go high before another start edge is accepted.
      BREAK_WAIT: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.rx_byte   = byte_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  logic hwclk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  int   valid_cnt, ferr_cnt, busy_cnt, overlap_cnt;
  logic prev_busy, busy_at_valid, busy_before_valid;
  logic [7:0] vbytes[$];
  int         vcycs[$];

  uart_rx_deserializer_if bus ();

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .hwclk (hwclk),
    .reset (reset),
    .bus   (bus)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  always @(posedge hwclk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge hwclk) begin
    if (bus.rx_valid === 1'b1) begin
      valid_cnt++;
      vbytes.push_back(bus.rx_byte);
      vcycs.push_back(cyc);
      busy_at_valid     = bus.busy;
      busy_before_valid = prev_busy;
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) overlap_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    prev_busy = bus.busy;
  end

  task automatic drive_bit(input logic v);
    bus.rx_data = v;
    repeat (CPB) @(negedge hwclk);
  endtask

  task automatic idle(input int n);
    bus.rx_data = 1'b1;
    repeat (n) @(negedge hwclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int sc);
    sc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    bus.rx_data = 1'b1;
  endtask

  task automatic clear_log();
    vbytes.delete();
    vcycs.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_data = 1'b1;
    repeat (3) @(negedge hwclk);
    checks++; if (bus.rx_byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte: got %0h expected 00", bus.rx_byte); end
    checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
    idle(5);
    checks++; if (bus.busy !== 1'b0 || valid_cnt != 0) begin failures++; $display("FAIL idle_after_reset: busy=%b valids=%0d expected 0/0", bus.busy, valid_cnt); end
  endtask

  task automatic test_single_byte();
    int sc, v0, f0;
    clear_log();
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, sc);
    idle(8);
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (vbytes.size() < 1 || vbytes[0] !== 8'h55) begin failures++; $display("FAIL single_byte: got %0h expected 55", (vbytes.size() > 0) ? vbytes[0] : 8'hxx); end
    checks++; if (vcycs.size() < 1 || vcycs[0] - sc != 155) begin failures++; $display("FAIL single_latency: got %0d expected 155", (vcycs.size() > 0) ? vcycs[0] - sc : -1); end
    checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL single_no_ferr: got %0d expected %0d", ferr_cnt, f0); end
    checks++; if (busy_before_valid !== 1'b1 || busy_at_valid !== 1'b0) begin failures++; $display("FAIL single_busy_fall: before=%b at=%b expected 1/0", busy_before_valid, busy_at_valid); end
    checks++; if (bus.rx_byte !== 8'h55) begin failures++; $display("FAIL single_hold: got %0h expected 55", bus.rx_byte); end
  endtask

  task automatic test_back_to_back();
    int sc1, sc2;
    clear_log();
    send_frame(8'hA3, 1'b1, sc1);
    send_frame(8'h00, 1'b1, sc2);
    idle(8);
    checks++; if (vbytes.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", vbytes.size()); end
    checks++; if (vbytes.size() < 2 || vbytes[0] !== 8'hA3 || vbytes[1] !== 8'h00) begin failures++; $display("FAIL b2b_bytes: got %0h/%0h expected a3/00", (vbytes.size() > 0) ? vbytes[0] : 8'hxx, (vbytes.size() > 1) ? vbytes[1] : 8'hxx); end
    checks++; if (vcycs.size() < 2 || vcycs[1] - vcycs[0] != 160) begin failures++; $display("FAIL b2b_spacing: got %0d expected 160", (vcycs.size() > 1) ? vcycs[1] - vcycs[0] : -1); end
    checks++; if (bus.rx_byte !== 8'h00) begin failures++; $display("FAIL b2b_final: got %0h expected 00", bus.rx_byte); end
  endtask

  task automatic test_glitch();
    int sc, v0, f0, b0;
    clear_log();
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    bus.rx_data = 1'b0;
    repeat (5) @(negedge hwclk);
    idle(2 * CPB);
    checks++; if (busy_cnt == b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy: pulses=%0d busy=%b expected >0/0", busy_cnt - b0, bus.busy); end
    checks++; if (valid_cnt != v0 || ferr_cnt != f0) begin failures++; $display("FAIL glitch_no_strobe: valid=%0d ferr=%0d expected 0/0", valid_cnt - v0, ferr_cnt - f0); end
    send_frame(8'h3C, 1'b1, sc);
    idle(8);
    checks++; if (vbytes.size() != 1 || vbytes[0] !== 8'h3C) begin failures++; $display("FAIL glitch_next_byte: count=%0d byte=%0h expected 1/3c", vbytes.size(), bus.rx_byte); end
  endtask

  task automatic test_framing_error();
    int sc, v0, f0;
    clear_log();
    send_frame(8'h7E, 1'b1, sc);
    idle(8);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, sc);
    idle(CPB);
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (bus.rx_byte !== 8'h7E) begin failures++; $display("FAIL ferr_hold_byte: got %0h expected 7e", bus.rx_byte); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ferr_recover: busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_break();
    int sc, v0, f0;
    clear_log();
    v0 = valid_cnt; f0 = ferr_cnt;
    bus.rx_data = 1'b0;
    repeat (40 * CPB) @(negedge hwclk);
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL break_busy_held: got %b expected 1", bus.busy); end
    idle(6);
    checks++; if (bus.busy !== 1'b0 || valid_cnt != v0) begin failures++; $display("FAIL break_release: busy=%b valids=%0d expected 0/0", bus.busy, valid_cnt - v0); end
    send_frame(8'hF0, 1'b1, sc);
    idle(8);
    checks++; if (vbytes.size() != 1 || bus.rx_byte !== 8'hF0) begin failures++; $display("FAIL break_next_byte: count=%0d byte=%0h expected 1/f0", vbytes.size(), bus.rx_byte); end
  endtask

  task automatic test_reset_mid_frame();
    int sc, v0, f0;
    logic [7:0] b;
    b = 8'hC5;
    clear_log();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    bus.rx_data = b[4];
    repeat (CPB / 2) @(negedge hwclk);
    v0 = valid_cnt; f0 = ferr_cnt;
    reset = 1'b1;
    @(negedge hwclk);
    checks++; if (bus.rx_byte !== 8'h00 || bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL midreset_values: byte=%0h valid=%b ferr=%b busy=%b expected 00/0/0/0", bus.rx_byte, bus.rx_valid, bus.frame_err, bus.busy);
    end
    repeat (2) @(negedge hwclk);
    reset = 1'b0;
    idle(3 * CPB);
    checks++; if (valid_cnt != v0 || ferr_cnt != f0) begin failures++; $display("FAIL midreset_no_strobe: valid=%0d ferr=%0d expected 0/0", valid_cnt - v0, ferr_cnt - f0); end
    send_frame(8'h12, 1'b1, sc);
    idle(8);
    checks++; if (vbytes.size() != 1 || bus.rx_byte !== 8'h12) begin failures++; $display("FAIL midreset_next_byte: count=%0d byte=%0h expected 1/12", vbytes.size(), bus.rx_byte); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; failures = 0;
    valid_cnt = 0; ferr_cnt = 0; busy_cnt = 0; overlap_cnt = 0;
    prev_busy = 1'b0; busy_at_valid = 1'bx; busy_before_valid = 1'bx;
    reset = 1'b1;
    bus.rx_data = 1'b1;
    @(negedge hwclk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_break();
    test_reset_mid_frame();
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL valid_ferr_exclusive: got %0d expected 0", overlap_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
